// File: rtl/cookie_score_display_if.sv
// Control inputs and display/score outputs of the cookie score display stage.
// The design takes the slave side; a driver (the game core or a bench) takes the master side.
interface cookie_score_display_if;
    logic       en;
    logic       cookie_pulse;
    logic       clear;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic       saturated;

    modport master (
        output en, cookie_pulse, clear,
        input  seg, dp, score_tens, score_ones, saturated
    );

    modport slave (
        input  en, cookie_pulse, clear,
        output seg, dp, score_tens, score_ones, saturated
    );
endinterface

// File: rtl/cookie_score_display.sv
// Saturating two-digit BCD cookie score, shown on one 7-segment digit as a
// repeating tens / ones / blank sequence taken from a per-sequence snapshot.
module cookie_score_display #(
    parameter int DIGIT_CYCLES = 5000000,
    parameter int TMR_W        = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cookie_score_display_if.slave bus
);

    typedef enum logic [1:0] {
        SHOW_TENS = 2'd0,
        SHOW_ONES = 2'd1,
        BLANK     = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIGIT_CYCLES - 1);

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h00;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
        if (o == 4'd9) bcd_inc = {t + 4'd1, 4'd0};
        else           bcd_inc = {t, o + 4'd1};
    endfunction

    logic [3:0]       r_tens, r_ones;
    logic             r_sat;
    logic [3:0]       r_snap_tens, r_snap_ones;
    logic [TMR_W-1:0] r_tmr;
    state_t           r_state;
    logic [6:0]       r_seg;
    logic             r_dp;

    state_t     w_state_nxt;
    logic       w_snap_ld;
    logic       w_tmr_done;
    logic [7:0] w_inc;
    logic [6:0] w_seg_nxt;
    logic       w_dp_nxt;

    assign w_tmr_done = (r_tmr == TMR_LAST);
    assign w_inc      = bcd_inc(r_tens, r_ones);

    // Score: clear beats a simultaneous pulse; r_sat blocks counting past 99.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
            r_sat  <= 1'b0;
        end else if (bus.en) begin
            if (bus.clear) begin
                r_tens <= 4'd0;
                r_ones <= 4'd0;
                r_sat  <= 1'b0;
            end else if (bus.cookie_pulse && !r_sat) begin
                r_tens <= w_inc[7:4];
                r_ones <= w_inc[3:0];
                r_sat  <= (w_inc == 8'h99);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= '0;
        end else if (bus.en) begin
            r_tmr <= w_tmr_done ? '0 : r_tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SHOW_TENS;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_snap_ld   = 1'b0;
        w_seg_nxt   = 7'h00;
        w_dp_nxt    = 1'b0;
        if (bus.en && w_tmr_done) begin
            case (r_state)
                SHOW_TENS: w_state_nxt = SHOW_ONES;
                SHOW_ONES: w_state_nxt = BLANK;
                BLANK: begin
                    w_state_nxt = SHOW_TENS;
                    w_snap_ld   = 1'b1;
                end
                default:   w_state_nxt = SHOW_TENS;
            endcase
        end
        // Leading-zero tens is blanked; a zero ones digit is always shown.
        case (r_state)
            SHOW_TENS: w_seg_nxt = (r_snap_tens == 4'd0) ? 7'h00 : enc(r_snap_tens);
            SHOW_ONES: begin
                w_seg_nxt = enc(r_snap_ones);
                w_dp_nxt  = 1'b1;
            end
            default: begin
                w_seg_nxt = 7'h00;
                w_dp_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_tens <= 4'd0;
            r_snap_ones <= 4'd0;
        end else if (w_snap_ld) begin
            r_snap_tens <= r_tens;
            r_snap_ones <= r_ones;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'h00;
            r_dp  <= 1'b0;
        end else if (bus.en) begin
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.score_tens = r_tens;
    assign bus.score_ones = r_ones;
    assign bus.saturated  = r_sat;

endmodule

// File: doc/cookie_score_display.md
Name: cookie_score_display

Overview:
- Downstream display stage for the cookie game.
- Consumes the single-cycle "cookie eaten" pulse from the cookie machine and keeps a saturating two-digit BCD score, 00..99.
- Time-multiplexes tens digit, ones digit and a blank gap onto the single 7-segment display on uo_out.
- Top level maps {dp, seg[6:0]} directly onto uo_out[7:0].

Parameters:
- DIGIT_CYCLES, 5000000: enabled clock cycles each display phase lasts (0.5 s at 10 MHz); legal range ≥2.
- TMR_W, 23: timer width; must satisfy 2^TMR_W ≥ DIGIT_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  design enable; low freezes all state.
- cookie_pulse  input  1  one-cycle pulse per cookie eaten.
- clear  input  1  synchronous score clear.
- seg  output  7  segments a..g on seg[0]..seg[6], active-high, registered.
- dp  output  1  decimal point, high while ones digit shown, registered.
- score_tens  output  4  live BCD tens digit.
- score_ones  output  4  live BCD ones digit.
- saturated  output  1  high while score == 99.

Behaviour:
- Reset
  - One clock, clk. Reset is asynchronous, active-low on rst_n.
  - Reset values: score 00; snapshot 00; timer 0; state SHOW_TENS; seg 7'h00; dp 0; saturated 0.
- en low
  - Score, timer, FSM, snapshot and output registers all hold.
  - cookie_pulse and clear are ignored.
- Score, updated only when en=1
  - clear=1: score ← 00. Clear wins over a simultaneous cookie_pulse.
  - Else cookie_pulse=1 and score<99: BCD increment. Ones 9→0 carries into tens, e.g. 09→10, 39→40.
  - Else cookie_pulse=1 at 99: score stays 99 (saturates, no wrap).
  - score_tens, score_ones and saturated are registered. They reflect an update one cycle after the pulse edge.
  - A pulse held high for N enabled cycles counts N times.
- Timer
  - Counts 0..DIGIT_CYCLES-1 on enabled cycles.
  - At DIGIT_CYCLES-1 it returns to 0 and the FSM advances.
  - Each phase therefore lasts exactly DIGIT_CYCLES enabled cycles.
- FSM, 3 states
  - Order: SHOW_TENS → SHOW_ONES → BLANK → SHOW_TENS.
  - On the BLANK→SHOW_TENS transition, the snapshot loads the current registered score.
  - The displayed tens/ones pair is therefore always from one instant; score changes mid-sequence are not visible until the next sequence.
  - clear does not reset the FSM or timer.
- Output mapping, registered from state+snapshot; seg/dp lag a state change by 1 cycle
  - SHOW_TENS: seg = enc(snap_tens), dp=0. If snap_tens==0, seg=7'h00 (leading-zero blank).
  - SHOW_ONES: seg = enc(snap_ones), dp=1. A ones digit of 0 is always shown.
  - BLANK: seg=7'h00, dp=0.
- Encoding enc()
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Non-BCD values cannot occur; implementation decodes them to 7'h00.
- Reset mid-sequence
  - Asynchronously returns everything to reset values.
  - The next sequence starts with SHOW_TENS, showing snapshot 00 → blank tens, then ones "0".

Test Plan (DIGIT_CYCLES=4, TMR_W=3):
- Reset then en=1, no pulses → repeating 12-cycle pattern, one cycle behind the FSM: seg=00/dp=0 ×4, seg=3F/dp=1 ×4, seg=00/dp=0 ×4.
- 23 single-cycle pulses with en=1 → score_tens=2, score_ones=3. Next sequence after BLANK shows seg=5B/dp=0 ×4, then seg=4F/dp=1 ×4.
- 120 pulses → score saturates: score_tens=9, score_ones=9, saturated=1 from the 99th pulse onward. Display shows 6F dp=0, then 6F dp=1.
- clear and cookie_pulse asserted in the same cycle at score 41 → score 00, saturated=0. Display keeps the old snapshot (66, then 06) until the next BLANK→SHOW_TENS, then shows 00, 3F.
- en=0 for 10 cycles mid SHOW_ONES with pulses applied → seg, dp, score and timer unchanged. After en=1, the phase completes the remaining count exactly.
- rst_n low asynchronously mid SHOW_TENS at score 57 → seg=00, dp=0, score 00 immediately, without waiting for a clk edge. Sequence restarts at SHOW_TENS.
